// File: rtl/fifo_wr_arb.sv
// Write-side arbiter for the async FIFO: round-robin with a per-source burst limit
// feeding a single registered write port (wen/wdata/wid), backpressured by full.
module fifo_wr_arb #(
  parameter int unsigned D_SIZE    = 8,
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                      wclk,
  input  logic                      rstn,
  input  logic [N_SRC-1:0]          req,
  input  logic [N_SRC*D_SIZE-1:0]   src_data,
  output logic [N_SRC-1:0]          ack,
  input  logic                      full,
  output logic                      wen,
  output logic [D_SIZE-1:0]         wdata,
  output logic [$clog2(N_SRC)-1:0]  wid
);

  localparam int unsigned IW = $clog2(N_SRC);
  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  logic [D_SIZE-1:0] lane [N_SRC];
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [CW-1:0]     cnt, cnt_nxt, ncnt;
  logic [IW-1:0]     sel, idx;
  logic              found, free, load;
  logic              wen_nxt;
  logic [D_SIZE-1:0] wdata_nxt;
  logic [IW-1:0]     wid_nxt;

  for (genvar g = 0; g < N_SRC; g++) begin : g_lane
    assign lane[g] = src_data[g*D_SIZE +: D_SIZE];
  end

  // First requesting source at or after ptr, wrapping modulo N_SRC
  always_comb begin : select
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = IW'((32'(ptr) + k) % N_SRC);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // The output register is free when empty or when its word leaves this cycle
  assign free = ~wen | ~full;
  assign load = free & found;

  always_comb begin : next_state
    ack       = '0;
    wen_nxt   = wen;
    wdata_nxt = wdata;
    wid_nxt   = wid;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    ncnt      = (sel == ptr) ? CW'(cnt + 1'b1) : CW'(1);
    if (load) begin
      ack       = N_SRC'(1) << sel;
      wen_nxt   = 1'b1;
      wdata_nxt = lane[sel];
      wid_nxt   = sel;
      if (ncnt == CW'(BURST_MAX)) begin
        ptr_nxt = IW'((32'(sel) + 1) % N_SRC);
        cnt_nxt = '0;
      end else begin
        ptr_nxt = sel;
        cnt_nxt = ncnt;
      end
    end else if (free) begin
      wen_nxt = 1'b0;
    end
    if (!rstn) ack = '0;
  end

  always_ff @(posedge wclk or negedge rstn) begin : regs
    if (!rstn) begin
      wen   <= 1'b0;
      wdata <= '0;
      wid   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      wen   <= wen_nxt;
      wdata <= wdata_nxt;
      wid   <= wid_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized scoreboard bench for fifo_wr_arb: a behavioural arbiter model predicts
// acks and pushes expected FIFO words; an independent monitor checks every write.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int BM = 4;

  typedef struct packed {
    logic [1:0]   id;
    logic [D-1:0] d;
  } exp_t;

  logic           wclk;
  logic           rstn;
  logic [N-1:0]   req;
  logic [N*D-1:0] src_data;
  logic [N-1:0]   ack;
  logic           full;
  logic           wen;
  logic [D-1:0]   wdata;
  logic [1:0]     wid;

  fifo_wr_arb #(.D_SIZE(D), .N_SRC(N), .BURST_MAX(BM)) dut (
    .wclk(wclk), .rstn(rstn), .req(req), .src_data(src_data), .ack(ack),
    .full(full), .wen(wen), .wdata(wdata), .wid(wid)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic [D-1:0] seq [N];
  logic [N-1:0] ack_d;
  exp_t         q[$];
  int           n_chk, n_fail, n_wr, n_push, n_disc;
  int           m_ptr, m_cnt, m_wen;
  int           grants [N];

  always_comb begin
    for (int i = 0; i < N; i++) src_data[i*D +: D] = seq[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ptr = 0;
    m_cnt = 0;
    m_wen = 0;
    n_disc += q.size();
    q.delete();
    ack_d = '0;
  endtask

  // One cycle: drive inputs, predict and check ack/wen, update the model
  task automatic step(input logic [N-1:0] r, input logic f);
    int   s, nc;
    bit   mfree;
    exp_t e;
    logic [N-1:0] ea;
    @(negedge wclk);
    for (int i = 0; i < N; i++) if (ack_d[i]) seq[i]++;
    rstn = 1'b1;
    req  = r;
    full = f;
    #1;
    mfree = (m_wen == 0) || !f;
    s = -1;
    for (int k = 0; k < N; k++)
      if (s < 0 && r[(m_ptr + k) % N]) s = (m_ptr + k) % N;
    ea = (mfree && s >= 0) ? N'(1 << s) : '0;
    chk("ack", 32'(ack), 32'(ea));
    chk("wen", 32'(wen), 32'(m_wen));
    ack_d = ack;
    if (mfree && s >= 0) begin
      e.id = 2'(s);
      e.d  = seq[s];
      q.push_back(e);
      n_push++;
      grants[s]++;
      nc = (s == m_ptr) ? m_cnt + 1 : 1;
      if (nc == BM) begin
        m_ptr = (s + 1) % N;
        m_cnt = 0;
      end else begin
        m_ptr = s;
        m_cnt = nc;
      end
      m_wen = 1;
    end else if (mfree) begin
      m_wen = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge wclk);
    rstn = 1'b0;
    req  = '1;
    full = 1'b0;
    #1;
    chk("rst_wen", 32'(wen), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_wid", 32'(wid), 0);
    chk("rst_ack", 32'(ack), 0);
    model_clear();
    for (int i = 0; i < N; i++) seq[i] = '0;
  endtask

  // Monitor: every accepted FIFO write must match the oldest acked word
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      #2;
      if (rstn && wen && !full) begin
        n_wr++;
        if (q.size() == 0) begin
          chk("unexpected_write", 32'(q.size()), 1);
        end else begin
          e = q.pop_front();
          chk("wdata", 32'(wdata), 32'(e.d));
          chk("wid", 32'(wid), 32'(e.id));
        end
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; n_wr = 0; n_push = 0; n_disc = 0;
    rstn = 1'b0; req = '1; full = 1'b0; ack_d = '0;
    for (int i = 0; i < N; i++) begin seq[i] = '0; grants[i] = 0; end

    do_reset();
    step(4'hF, 1'b0);
    chk("first_ack", 32'(ack_d), 1);

    // Single source streaming
    for (int k = 0; k < 10; k++) begin
      step(4'b0100, 1'b0);
      chk("single_ack", 32'(ack_d), 32'h4);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("single_drained", 32'(q.size()), 0);

    // Fairness: bursts of BM per source from a reset pointer
    do_reset();
    for (int i = 0; i < N; i++) grants[i] = 0;
    for (int k = 0; k < 32; k++) begin
      step(4'hF, 1'b0);
      chk("rr_order", 32'(ack_d), 32'(1 << ((k / BM) % N)));
    end
    for (int i = 0; i < N; i++) chk("rr_count", 32'(grants[i]), 8);

    // Backpressure with word 5 held
    do_reset();
    for (int k = 0; k < 6; k++) step(4'b0001, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 1'b1);
      chk("bp_ack", 32'(ack_d), 0);
      chk("bp_hold", 32'(wdata), 5);
    end
    step(4'b0001, 1'b0);
    chk("bp_resume", 32'(ack_d), 1);

    // Short burst: src0 drops after two words, src2 takes over
    do_reset();
    step(4'b0101, 1'b0);
    step(4'b0101, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(4'b0100, 1'b0);
      chk("short_burst", 32'(ack_d), 32'h4);
    end

    // Randomized traffic and backpressure
    for (int k = 0; k < 400; k++)
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3));

    // Reset while a word is stalled in the output register
    step(4'hF, 1'b0);
    step(4'hF, 1'b1);
    chk("stall_wen", 32'(wen), 1);
    @(negedge wclk);
    for (int i = 0; i < N; i++) if (ack_d[i]) seq[i]++;
    full = 1'b1;
    rstn = 1'b0;
    #1;
    chk("midrst_wen", 32'(wen), 0);
    chk("midrst_ack", 32'(ack), 0);
    model_clear();
    step(4'hF, 1'b0);
    chk("midrst_restart", 32'(ack_d), 1);

    for (int k = 0; k < 3; k++) step(4'b0000, 1'b0);
    chk("final_drained", 32'(q.size()), 0);
    chk("write_count", 32'(n_wr), 32'(n_push - n_disc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Write-side arbiter for the asynchronous FIFO in the `wclk` domain. It shares the single FIFO write port (`wen`/`wdata`, backpressured by `full`) among `N_SRC` requesters using round-robin with a per-source burst limit. It has a one-word output register, so `wen`/`wdata` are registered. Sources use a req/ack pop handshake: the word on a source's data lane is consumed in the cycle its `ack` is high.

## Interface
Parameters:
- `D_SIZE`, 8, FIFO data width.
- `N_SRC`, 4, number of requesters, 2..8.
- `BURST_MAX`, 4, maximum consecutive words granted to one source before the pointer advances, ≥1.

Ports:
- `wclk`  in  1  write-domain clock; all state on posedge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req`  in  N_SRC  per-source request; `req[i]` high means `src_data` lane i holds a valid word.
- `src_data`  in  N_SRC*D_SIZE  per-source data; lane i is bits `[i*D_SIZE +: D_SIZE]`.
- `ack`  out  N_SRC  one-hot pop strobe, combinational; the source advances its word at the posedge where `ack[i]` is high.
- `full`  in  1  FIFO full flag, synchronous to `wclk`.
- `wen`  out  1  FIFO write enable, registered.
- `wdata`  out  D_SIZE  FIFO write data, registered.
- `wid`  out  clog2(N_SRC)  source index of the word in `wdata`, registered.

## Operation
- Output register: a valid word is held in `wdata`/`wid` whenever `wen`=1. The FIFO accepts the word at a posedge where `wen & ~full`.
- Load condition:
  - `free = ~wen | ~full`.
  - `load = free & (|req)`.
  - When `load` is high, the selected source s gets `ack[s]=1` and its lane is captured into `wdata`; `wid<=s` and `wen<=1`.
- Drain: if `free` is high and `req` is all zero, `wen<=0`. `wdata` and `wid` hold their last values.
- Stall: if `wen & full`, then `wen`, `wdata` and `wid` hold and `ack` is all zero.
- Selection: priority pointer `ptr`; s is the first i with `req[i]` in order `ptr, ptr+1, … ptr+N_SRC-1`, modulo `N_SRC`.
- Burst bookkeeping on each load:
  - `ncnt = (s==ptr) ? cnt+1 : 1`.
  - If `ncnt==BURST_MAX`: `ptr<=(s+1) mod N_SRC`, `cnt<=0`.
  - Else: `ptr<=s`, `cnt<=ncnt`.
  - `cnt` width is clog2(BURST_MAX+1).
- `ack` is a function of `req`, `full`, `wen`, `ptr` and `cnt` only. At most one bit is set, and never a bit whose `req` is low.
- Once acked, a word is owned by the arbiter and is written to the FIFO exactly once, unless reset intervenes.

## Timing
- Reset values: `wen=0`, `wdata=0`, `wid=0`, `ptr=0`, `cnt=0`. `ack` is forced to 0 while `rstn`=0.
- Latency: a word acked at posedge k is on `wdata` after k. It is written to the FIFO at posedge k+1 if `full`=0.
- Throughput: 1 word per cycle while `full`=0 and any `req` is high. A new word is loaded in the same cycle the held word is accepted, with no bubble.
- `full` rising while `wen`=1: the word is held with no loss and no duplicate. It is written at the first posedge with `full`=0, and `ack` resumes in that same cycle.
- `full`=1 with `wen`=0: `free`=1, so one word is loaded and then stalls.
- A requester dropping `req` mid-burst: the pointer moves on at the next load via the `s!=ptr` rule.
- `BURST_MAX`=1 gives pure round-robin.
- `rstn` asserted mid-operation: all registers clear immediately. A held (already acked) word is discarded. After release, arbitration restarts at source 0.

## Test plan
- Reset: drive `rstn`=0 with `req`=4'hF and `full`=0. Expect `wen`=0, `wdata`=0, `wid`=0, `ack`=0; after release, first `ack`=4'b0001.
- Single source: `req`=4'b0100, lane 2 counting 0,1,2… on ack, `full`=0 for 10 cycles. Expect `ack[2]` every cycle, `wen`=1 from cycle 1, FIFO receives 0..9 in order, `wid`=2.
- Fairness: all `req` high, `BURST_MAX`=4, 32 cycles. Expect grant order 0×4, 1×4, 2×4, 3×4, repeated, and 8 words per source.
- Backpressure: with `wen`=1 and `wdata`=5, raise `full` for 3 cycles. Expect `wdata`=5 held, `ack`=0 for all 3 cycles, 5 written once at release, and no gaps or duplicates in the 0..N sequence.
- Short burst: src0 requests for 2 words then drops, while src2 is requesting. Expect a switch to src2 with `cnt`=1, src2 granted 4 words, then the pointer moves to 3 or wraps.
- Mid-stall reset: with `wen`=1 and `full`=1, pulse `rstn` low. Expect `wen`=0 immediately, no write of the held word, and `ptr` restarting at 0.
